// File: rtl/median_filter.sv
// 3x3 streaming median over raster-ordered 8-bit pixels using two line buffers.
// Latency 5 clocks, one pixel per clock, no backpressure; blanking cycles become pipeline bubbles.
module median_filter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [7:0]  gray_value,
  output logic [7:0]  median_value,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        median_valid
);

  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef struct packed {
    logic        vld;
    logic        bdr;
    logic [10:0] h;
    logic [10:0] v;
  } meta_t;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic          active;
  logic [AW-1:0] addr;
  assign active = (hcount < 11'(H_ACTIVE)) && (vcount < 11'(V_ACTIVE));
  assign addr   = hcount[AW-1:0];

  // Read-first line buffers: A holds row v-1, B holds row v-2 at each column.
  logic [7:0] line_a [H_ACTIVE];
  logic [7:0] line_b [H_ACTIVE];
  logic [7:0] rd_a_q, rd_b_q;

  always_ff @(posedge clk) begin
    rd_a_q <= line_a[addr];
    rd_b_q <= line_b[addr];
    if (active && !rst) begin
      line_a[addr] <= gray_value;
      line_b[addr] <= line_a[addr];
    end
  end

  meta_t      s1_q, s2_q, s3_q, s4_q;
  logic       s1_act_q;
  logic [7:0] s1_pix_q;
  logic [7:0] win_q [3][3];
  logic [7:0] s3_ctr_q, s4_ctr_q;

  logic [7:0] row_min_d [3];
  logic [7:0] row_med_d [3];
  logic [7:0] row_max_d [3];
  logic [7:0] row_min_q [3];
  logic [7:0] row_med_q [3];
  logic [7:0] row_max_q [3];
  logic [7:0] col_lo_d, col_md_d, col_hi_d;
  logic [7:0] col_lo_q, col_md_q, col_hi_q;
  logic [7:0] med_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s1_act_q <= 1'b0;
      s1_pix_q <= '0;
    end else begin
      s1_act_q <= active;
      s1_pix_q <= gray_value;
      s1_q.vld <= active && (hcount != 11'd0) && (vcount != 11'd0);
      s1_q.bdr <= (hcount == 11'd1) || (vcount == 11'd1);
      s1_q.h   <= hcount - 11'd1;
      s1_q.v   <= vcount - 11'd1;
    end
  end

  // Rows 0..2 are v-2..v, columns 0..2 are h-2..h; centre sits at [1][1].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (s1_act_q) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= rd_b_q;
      win_q[1][2] <= rd_a_q;
      win_q[2][2] <= s1_pix_q;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_min_d[r] = min2(min2(win_q[r][0], win_q[r][1]), win_q[r][2]);
      row_med_d[r] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
      row_max_d[r] = max2(max2(win_q[r][0], win_q[r][1]), win_q[r][2]);
    end
  end

  assign col_lo_d = max2(max2(row_min_q[0], row_min_q[1]), row_min_q[2]);
  assign col_md_d = med3(row_med_q[0], row_med_q[1], row_med_q[2]);
  assign col_hi_d = min2(min2(row_max_q[0], row_max_q[1]), row_max_q[2]);
  assign med_d    = s4_q.bdr ? s4_ctr_q : med3(col_lo_q, col_md_q, col_hi_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      s3_ctr_q <= '0;
      s4_ctr_q <= '0;
      col_lo_q <= '0;
      col_md_q <= '0;
      col_hi_q <= '0;
      for (int r = 0; r < 3; r++) begin
        row_min_q[r] <= '0;
        row_med_q[r] <= '0;
        row_max_q[r] <= '0;
      end
    end else begin
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      s4_q     <= s3_q;
      s3_ctr_q <= win_q[1][1];
      s4_ctr_q <= s3_ctr_q;
      col_lo_q <= col_lo_d;
      col_md_q <= col_md_d;
      col_hi_q <= col_hi_d;
      for (int r = 0; r < 3; r++) begin
        row_min_q[r] <= row_min_d[r];
        row_med_q[r] <= row_med_d[r];
        row_max_q[r] <= row_max_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      median_value <= '0;
      hcount_out   <= '0;
      vcount_out   <= '0;
      median_valid <= 1'b0;
    end else begin
      median_valid <= s4_q.vld;
      if (s4_q.vld) begin
        median_value <= med_d;
        hcount_out   <= s4_q.h;
        vcount_out   <= s4_q.v;
      end
    end
  end

endmodule

// File: tb/tb_median_filter.sv
// Randomized and directed frames for median_filter, checked by a queue scoreboard
// fed from a whole-frame reference model.
module tb_median_filter;
  localparam int H  = 20;
  localparam int V  = 11;
  localparam int HB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic [7:0]  gray_value;
  logic [7:0]  median_value;
  logic [10:0] hcount_out, vcount_out;
  logic        median_valid;

  median_filter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .gray_value(gray_value),
    .median_value(median_value), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .median_valid(median_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int val;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   img [V][H];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   ignore = 0;
  bit   quiet = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Median of the true 3x3 neighbourhood of the frame, raw pixel on the top/left border.
  function automatic int ref_out(input int cx, input int cy);
    int w[9];
    int n;
    int t;
    if (cx == 0 || cy == 0) return img[cy][cx];
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        w[n] = img[cy+dy][cx+dx];
        n++;
      end
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && w[j-1] > w[j]; j--) begin
        t = w[j]; w[j] = w[j-1]; w[j-1] = t;
      end
    return w[4];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic drive(input int h, input int v, input int pix, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    hcount     = 11'(h);
    vcount     = 11'(v);
    gray_value = 8'(pix);
    rst        = r;
    if (!r && !ignore && h >= 1 && v >= 1 && h < H && v < V) begin
      e.h   = h - 1;
      e.v   = v - 1;
      e.val = ref_out(h - 1, v - 1);
      e.due = cyc + 5;
      sbq.push_back(e);
    end
  endtask

  task automatic mid_reset();
    drive(10, 5, img[5][10], 1'b1);
    while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
    drive(H, 5, 0, 1'b1);
    drive(H, 5, 0, 1'b0);
    chk("midrst_valid", int'(median_valid), 0);
    chk("midrst_value", int'(median_value), 0);
    chk("midrst_hout", int'(hcount_out), 0);
    chk("midrst_vout", int'(vcount_out), 0);
    quiet = 1;
    repeat (8) drive(H, 5, 0, 1'b0);
    quiet  = 0;
    ignore = 1;
  endtask

  task automatic run_frame(input int mode, input bit with_rst);
    int pix;
    ignore = 0;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        case (mode)
          0:       img[v][h] = 77;
          1, 3:    img[v][h] = h + v;
          2:       img[v][h] = (h == 7 && v == 4) ? 255 : 0;
          default: img[v][h] = int'($urandom_range(0, 255));
        endcase
    if (mode == 3) begin
      img[2][0] = 200;
      img[0][3] = 200;
    end
    for (int v = 0; v <= V; v++)
      for (int h = 0; h < H + HB; h++) begin
        pix = (v < V && h < H) ? img[v][h] : int'($urandom_range(0, 255));
        if (with_rst && v == 5 && h == 10) mid_reset();
        else drive(h, v, pix, 1'b0);
      end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (quiet) begin
      chk("quiet_valid", int'(median_valid), 0);
    end else if (median_valid) begin
      if (sbq.size() == 0) begin
        if (!ignore) chk("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("value", int'(median_value), e.val);
        chk("hcount_out", int'(hcount_out), e.h);
        chk("vcount_out", int'(vcount_out), e.v);
        chk("latency", cyc, e.due);
        chk("h_in_range", int'(hcount_out < 11'(H - 1)), 1);
        chk("v_in_range", int'(vcount_out < 11'(V - 1)), 1);
        pulses++;
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("missing_valid", 0, 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    hcount     = 11'd2000;
    vcount     = 11'd2000;
    gray_value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(median_valid), 0);
    chk("rst_value", int'(median_value), 0);
    chk("rst_hout", int'(hcount_out), 0);
    chk("rst_vout", int'(vcount_out), 0);
    drive(H, V, 0, 1'b0);

    pulses = 0;
    run_frame(0, 1'b0);
    chk("const_pulses", pulses, 190);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(3, 1'b0);
    run_frame(4, 1'b0);
    run_frame(4, 1'b1);
    pulses = 0;
    run_frame(0, 1'b0);
    chk("post_rst_pulses", pulses, 190);

    repeat (10) drive(H, V, 0, 1'b0);
    chk("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_filter.md
# median_filter

Streaming 3x3 median filter that produces the `median_value` pixel stream consumed by `sobel_detect`. It takes raster-ordered 8-bit grayscale pixels tagged with `hcount`/`vcount` and buffers two previous lines in on-chip RAM. Each output pixel is the median of its 3x3 neighbourhood, emitted with its own delayed coordinates so `sobel_detect` can be driven directly. It sits between the camera/grayscale conversion stage and edge detection.

## Interface
- `H_ACTIVE`, 640, active pixels per line; also the line-buffer depth.
- `V_ACTIVE`, 480, active lines per frame.
- `clk`  input  1  pixel clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `hcount`  input  11  column of `gray_value`; values >= `H_ACTIVE` are blanking.
- `vcount`  input  11  row of `gray_value`; values >= `V_ACTIVE` are blanking.
- `gray_value`  input  8  input pixel, sampled every clock.
- `median_value`  output  8  filtered pixel for (`hcount_out`, `vcount_out`).
- `hcount_out`  output  11  column of the window centre.
- `vcount_out`  output  11  row of the window centre.
- `median_valid`  output  1  high for exactly one cycle per produced pixel.

## Operation
- **Active input:** `hcount < H_ACTIVE` and `vcount < V_ACTIVE`. All other cycles are ignored: no buffer write, no window shift, and no valid output.
- **Line buffers:** two buffers, A and B, each `H_ACTIVE` x 8 and addressed by `hcount`.
  - On an active input: read A[h] and B[h], then write B[h] <= old A[h] and A[h] <= `gray_value`. Read-before-write at the same address.
  - Column h therefore presents rows v, v-1 and v-2.
- **Window:** 3x3 register array that shifts one column per active input.
  - When input (h, v) enters, the window holds columns h-2..h and rows v-2..v.
  - The centre is (h-1, v-1).
- **Output generation:** only for active inputs with h >= 1 and v >= 1. This produces centres x in 0..`H_ACTIVE`-2 and y in 0..`V_ACTIVE`-2. The last column and last row are never emitted.
- **Border:** if the centre has x == 0 or y == 0, `median_value` is the raw centre pixel, delayed to the same latency.
- **Interior median:** a pipelined 3-stage network.
  - Stage 1: sort each row of three.
  - Stage 2: column max of the row minima, column median of the row medians, column min of the row maxima.
  - Stage 3: median of those three values.
  - All arithmetic is unsigned 8-bit compares; there is no widening.
- **Coordinates:** `hcount_out` = h-1 and `vcount_out` = v-1. They are carried down the pipeline alongside the data.
- **Reset:** synchronous.
  - Clears the window, all pipeline registers and valid bits.
  - Drives `median_value` = 0, `hcount_out` = 0, `vcount_out` = 0, `median_valid` = 0 from the cycle after reset is sampled.
  - Line-buffer RAM is not cleared.
- **Reset mid-frame:** outputs from the rest of that frame may use stale line data. Outputs are correct from the next frame (`vcount` == 0) onward.

## Timing
- Fixed latency of 5 clocks from sampling an active pixel at (h, v) to `median_valid` for centre (h-1, v-1). The stages are:
  1. Input/RAM read.
  2. Window shift.
  3. Row sort.
  4. Column stage.
  5. Final median plus output register.
- Full throughput: one pixel per clock. No stalls and no backpressure.
- `median_valid` is registered. All outputs change only on the rising edge of `clk`.
- Blanking cycles inject bubbles into the pipeline. Valid outputs always appear exactly 5 cycles after their source input, with gaps preserved.
- Simultaneous `rst` and active input: reset wins, and the pixel is neither written nor emitted.
- Line-buffer write and read to the same address in one cycle must return old data. Use a read-first RAM or a registered bypass.

## Test plan
Benches use `H_ACTIVE`=20, `V_ACTIVE`=11 and 4 blanking cycles per line.
- **Constant frame:** `gray_value` = 77 for the whole frame -> every `median_valid` pulse carries 77. There are 19x10 = 190 pulses per frame.
- **Ramp:** `gray_value` = `hcount` + `vcount` -> each interior output equals `hcount_out` + `vcount_out`. Example: centre (5,3) gives 8, appearing 5 clocks after input (6,4).
- **Impulse:** background 0 with a single 255 at (7,4) -> all outputs are 0, including centre (7,4).
- **Border:** the ramp frame with 200 at (0,2) and at (3,0) -> outputs at centres (0,2) and (3,0) equal 200 (raw pass-through). (1,2) stays the median.
- **Blanking / valid count:** check `median_valid` never asserts during blanking, and that `hcount_out` never reaches 19 and `vcount_out` never reaches 10.
- **Reset mid-frame:** assert `rst` for 2 cycles at input (10,5) -> all outputs are 0 the next cycle and no valid pulses appear until input resumes. The constant-frame check passes on the following full frame.
